branch_redirect_ctrl: RTL and testbench

BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

---
 rtl/branch_redirect_ctrl_pkg.sv | 13 +
 rtl/branch_redirect_ctrl_sat_counter.sv | 35 +++
 rtl/branch_redirect_ctrl.sv | 125 ++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and default widths for the branch redirect controller.
package branch_redirect_ctrl_pkg;

  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefCntW  = 16;

  // IDLE: redirect driven straight from EX; HOLD: replay a captured target while stalled.
  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StHold = 1'b1
  } state_e;

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d, count_q;

  // Next count: clear, else increment unless already all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: zero-latency PC redirect and pipeline flush on a taken
// branch in EX, with a hold state that replays the target while the PC is stalled.
// Also counts resolved and taken branches.
// Build option: define BR_DELAY_SLOT_EN to keep flush_idex low (delay-slot instruction
// in ID is allowed to proceed); only flush_ifid asserts on redirect.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic              br_sel,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              pc_en,
  input  logic              stat_clr,
  output logic              pc_sel,
  output logic [ADDR_W-1:0] pc_redirect,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              redirect_busy,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  taken_count
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] hold_q, hold_d;
  logic              resolved, take;
  logic              br_inc, taken_inc;

  assign resolved = ex_valid & ex_is_branch;
  assign take     = resolved & br_sel;

  // Next state, target capture and counter increments. A branch is counted only at the
  // edge where the PC actually advances past it, so stalls never double count.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    br_inc    = 1'b0;
    taken_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (take && !pc_en) begin
          state_d = StHold;
          hold_d  = br_target;
        end else if (resolved && pc_en) begin
          br_inc    = 1'b1;
          taken_inc = br_sel;
        end
      end
      StHold: begin
        // EX inputs may be wrong-path or a re-presentation of the held branch: ignored.
        if (pc_en) begin
          state_d   = StIdle;
          br_inc    = 1'b1;
          taken_inc = 1'b1;
        end
      end
    endcase
  end

  // FSM state and held redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Redirect outputs; IDLE path is combinational for zero-latency redirect, and all
  // redirect controls are forced low while reset is asserted.
  always_comb begin
    pc_sel        = 1'b0;
    pc_redirect   = br_target;
    flush_ifid    = 1'b0;
    redirect_busy = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        StIdle: begin
          pc_sel     = take;
          flush_ifid = take;
        end
        StHold: begin
          pc_sel        = 1'b1;
          pc_redirect   = hold_q;
          flush_ifid    = 1'b1;
          redirect_busy = 1'b1;
        end
      endcase
    end
  end

`ifdef BR_DELAY_SLOT_EN
  assign flush_idex = 1'b0;
`else
  assign flush_idex = flush_ifid;
`endif

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_br_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stat_clr),
    .inc   (br_inc),
    .count (br_count)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stat_clr),
    .inc   (taken_inc),
    .count (taken_count)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl (narrow counters so saturation is reachable).
module tb_branch_redirect_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 4;
`ifdef BR_DELAY_SLOT_EN
  localparam bit DsEn = 1'b1;
`else
  localparam bit DsEn = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          ex_valid, ex_is_branch, br_sel, pc_en, stat_clr;
  logic [AW-1:0] br_target;
  logic          pc_sel, flush_ifid, flush_idex, redirect_busy;
  logic [AW-1:0] pc_redirect;
  logic [CW-1:0] br_count, taken_count;

  int errors = 0;
  int checks = 0;

  branch_redirect_ctrl #(
    .ADDR_W (AW),
    .CNT_W  (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_is_branch  (ex_is_branch),
    .br_sel        (br_sel),
    .br_target     (br_target),
    .pc_en         (pc_en),
    .stat_clr      (stat_clr),
    .pc_sel        (pc_sel),
    .pc_redirect   (pc_redirect),
    .flush_ifid    (flush_ifid),
    .flush_idex    (flush_idex),
    .redirect_busy (redirect_busy),
    .br_count      (br_count),
    .taken_count   (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic b, input logic s, input logic [AW-1:0] t,
                       input logic en);
    ex_valid     = v;
    ex_is_branch = b;
    br_sel       = s;
    br_target    = t;
    pc_en        = en;
  endtask

  // Tasks begin and end 1 time unit after a rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    stat_clr = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b1);
    #2;
    checks++;
    if ({pc_sel, flush_ifid, flush_idex, redirect_busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000",
               {pc_sel, flush_ifid, flush_idex, redirect_busy});
    end
    checks++;
    if ({br_count, taken_count} !== 8'h00) begin
      errors++;
      $display("FAIL reset_counts: got %h/%h expected 0/0", br_count, taken_count);
    end
    repeat (2) @(posedge clk);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  // Taken beq with pc_en=1: same-cycle redirect, counted at the next edge.
  task automatic test_taken_direct();
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b1);
    @(negedge clk);
    checks++;
    if ({pc_sel, flush_ifid, flush_idex, redirect_busy} !== {1'b1, 1'b1, !DsEn, 1'b0}) begin
      errors++;
      $display("FAIL taken_ctrl: got %b expected %b",
               {pc_sel, flush_ifid, flush_idex, redirect_busy}, {1'b1, 1'b1, !DsEn, 1'b0});
    end
    checks++;
    if (pc_redirect !== 32'h0000_0040) begin
      errors++;
      $display("FAIL taken_target: got %h expected 00000040", pc_redirect);
    end
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checks++;
    if ({br_count, taken_count} !== {4'd1, 4'd1}) begin
      errors++;
      $display("FAIL taken_counts: got %0d/%0d expected 1/1", br_count, taken_count);
    end
  endtask

  // Taken bne under stall: held target replayed, counted once at HOLD exit.
  task automatic test_hold();
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0080, 1'b0);
    @(negedge clk);
    checks++;
    if ({pc_sel, redirect_busy, pc_redirect} !== {1'b1, 1'b0, 32'h0000_0080}) begin
      errors++;
      $display("FAIL hold_entry: got sel=%b busy=%b pc=%h expected 1 0 00000080",
               pc_sel, redirect_busy, pc_redirect);
    end
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 32'h0000_00FC, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) pc_en = 1'b1;
      @(negedge clk);
      checks++;
      if ({pc_sel, flush_ifid, flush_idex, redirect_busy, pc_redirect} !==
          {1'b1, 1'b1, !DsEn, 1'b1, 32'h0000_0080}) begin
        errors++;
        $display("FAIL hold_cycle%0d: got ctrl=%b pc=%h expected ctrl=%b pc=00000080", i,
                 {pc_sel, flush_ifid, flush_idex, redirect_busy}, pc_redirect,
                 {1'b1, 1'b1, !DsEn, 1'b1});
      end
      checks++;
      if ({br_count, taken_count} !== {4'd1, 4'd1}) begin
        errors++;
        $display("FAIL hold_counts%0d: got %0d/%0d expected 1/1", i, br_count, taken_count);
      end
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checks++;
    if ({redirect_busy, br_count, taken_count} !== {1'b0, 4'd2, 4'd2}) begin
      errors++;
      $display("FAIL hold_exit: got busy=%b %0d/%0d expected 0 2/2",
               redirect_busy, br_count, taken_count);
    end
  endtask

  // Not-taken bgtz held by stall, then non-branch and invalid slots.
  task automatic test_not_taken();
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) pc_en = 1'b1;
      @(negedge clk);
      checks++;
      if ({pc_sel, flush_ifid, flush_idex, redirect_busy} !== 4'b0000) begin
        errors++;
        $display("FAIL nt_ctrl%0d: got %b expected 0000", i,
                 {pc_sel, flush_ifid, flush_idex, redirect_busy});
      end
      next_cycle();
    end
    checks++;
    if ({br_count, taken_count} !== {4'd3, 4'd2}) begin
      errors++;
      $display("FAIL nt_counts: got %0d/%0d expected 3/2", br_count, taken_count);
    end
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b1);
    @(negedge clk);
    checks++;
    if ({pc_sel, flush_ifid} !== 2'b00) begin
      errors++;
      $display("FAIL nonbranch_ctrl: got %b expected 00", {pc_sel, flush_ifid});
    end
    next_cycle();
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checks++;
    if ({br_count, taken_count} !== {4'd3, 4'd2}) begin
      errors++;
      $display("FAIL nonbranch_counts: got %0d/%0d expected 3/2", br_count, taken_count);
    end
  endtask

  // Saturation at all-ones, then clear winning over a simultaneous branch.
  task automatic test_saturate_clear();
    stat_clr = 1'b1;
    next_cycle();
    stat_clr = 1'b0;
    checks++;
    if ({br_count, taken_count} !== 8'h00) begin
      errors++;
      $display("FAIL clr_counts: got %0d/%0d expected 0/0", br_count, taken_count);
    end
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0300, 1'b1);
    repeat (15) next_cycle();
    checks++;
    if ({br_count, taken_count} !== 8'hFF) begin
      errors++;
      $display("FAIL sat_reach: got %0d/%0d expected 15/15", br_count, taken_count);
    end
    repeat (2) next_cycle();
    checks++;
    if ({br_count, taken_count} !== 8'hFF) begin
      errors++;
      $display("FAIL sat_hold: got %0d/%0d expected 15/15", br_count, taken_count);
    end
    stat_clr = 1'b1;
    next_cycle();
    stat_clr = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checks++;
    if ({br_count, taken_count} !== 8'h00) begin
      errors++;
      $display("FAIL clr_vs_inc: got %0d/%0d expected 0/0", br_count, taken_count);
    end
  endtask

  // Reset during HOLD abandons the pending redirect and its count.
  task automatic test_reset_mid_hold();
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0010, 1'b1);
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0400, 1'b0);
    next_cycle();
    checks++;
    if ({redirect_busy, br_count} !== {1'b1, 4'd1}) begin
      errors++;
      $display("FAIL rmh_pre: got busy=%b br=%0d expected 1 1", redirect_busy, br_count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pc_sel, flush_ifid, flush_idex, redirect_busy, br_count, taken_count} !==
        {4'b0000, 8'h00}) begin
      errors++;
      $display("FAIL rmh_reset: got ctrl=%b %0d/%0d expected 0000 0/0",
               {pc_sel, flush_ifid, flush_idex, redirect_busy}, br_count, taken_count);
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    next_cycle();
    checks++;
    if ({redirect_busy, pc_sel, br_count, taken_count} !== {2'b00, 8'h00}) begin
      errors++;
      $display("FAIL rmh_after: got busy=%b sel=%b %0d/%0d expected 0 0 0/0",
               redirect_busy, pc_sel, br_count, taken_count);
    end
  endtask

  initial begin
    test_reset();
    test_taken_direct();
    test_hold();
    test_not_taken();
    test_saturate_clear();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
